// File: rtl/mem_arb_defs.sv
// Shared definitions for the unified-memory arbiter.
// Contents: FSM state encoding, grant identifiers, and a helper that sizes
// counters from their maximum value.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the pipeline stages, the arbiter and the
// single-ported memory.
//   slave  : the arbiter's view (requests and mem_rdata in; data, done,
//            stall and memory strobes out)
//   master : the surrounding pipeline + memory view
//
// Handshake: if_req / d_req are levels that the requester holds, with stable
// address/we/wdata, until the matching one-cycle done pulse. At the edge that
// ends the done cycle the requester must drop the request or present a new
// one; a request still high in the following IDLE cycle is a new access.
// Requests are only looked at while the arbiter is idle. *_stall is simply
// req & ~done so a stage can freeze on it combinationally.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between instruction fetch and data access, plus the
// saturating starvation counter that protects fetch from a stream of data
// accesses.
// Ports: clk, reset (sync, active high); if_req, d_req (current requests);
// take (a grant is being made this cycle); gnt (GNT_IF / GNT_D);
// starve_cnt (consecutive data grants made while fetch was waiting).
module mem_arb_grant
  import mem_arb_defs::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = cnt_w(STARVE_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic          d_req,
  input  logic          take,
  output logic          gnt,
  output logic [SW-1:0] starve_cnt
);

  logic starved;

  // Data normally wins; fetch wins once it has been passed over STARVE_MAX times.
  assign starved = (starve_cnt == SW'(STARVE_MAX)) && if_req;
  assign gnt     = (d_req && !starved) ? GNT_D : GNT_IF;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (gnt == GNT_IF) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between IF-stage fetches and
// MEM-stage loads/stores. Each access runs IDLE -> ISSUE -> WAIT(MEM_LAT) ->
// RESP, i.e. 3+MEM_LAT cycles, and finishes with a one-cycle done pulse.
// Ports: clk, reset (sync, active high); bus (mem_arbiter_if.slave, all
// request/response/memory signals); state and starve_cnt expose the FSM
// state and starvation counter for observation.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  mem_arbiter_if.slave                    bus,
  output state_t                          state,
  output logic [cnt_w(STARVE_MAX)-1:0]    starve_cnt
);

  localparam int LW = cnt_w(MEM_LAT - 1);
  localparam int SW = cnt_w(STARVE_MAX);

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q;
  logic          gnt, gnt_q, we_q;
  logic          take, lat_last;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          if_done_q, d_done_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  assign take     = (state_q == IDLE) && (bus.if_req || bus.d_req);
  assign lat_last = (lat_q == LW'(MEM_LAT - 1));

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .take       (take),
    .gnt        (gnt),
    .starve_cnt (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. The memory strobes are loaded on the IDLE->ISSUE edge so they
  // are high exactly during ISSUE; done is loaded on the last WAIT edge so it
  // is high exactly during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q       <= '0;
      gnt_q       <= GNT_IF;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if (take) begin
        gnt_q    <= gnt;
        we_q     <= (gnt == GNT_D) && bus.d_we;
        mem_en_q <= 1'b1;
        mem_we_q <= (gnt == GNT_D) && bus.d_we;
        if (gnt == GNT_D) begin
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
        end else begin
          mem_addr_q  <= bus.if_addr;
        end
      end
      if (state_q == WAIT) begin
        if (lat_last) begin
          lat_q <= '0;
          if (gnt_q == GNT_IF) begin
            if_rdata_q <= bus.mem_rdata;
            if_done_q  <= 1'b1;
          end else begin
            if (!we_q) d_rdata_q <= bus.mem_rdata;  // stores keep old load data
            d_done_q <= 1'b1;
          end
        end else begin
          lat_q <= lat_q + LW'(1);
        end
      end
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_stall  = bus.if_req & ~if_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_stall   = bus.d_req & ~d_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model (grant order,
// access start/done cycles, memory image) checks a default build every
// cycle under directed and random request streams; a second MEM_LAT=1 build
// gets a directed fetch.
module tb_mem_arbiter;
  import mem_arb_defs::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int SW   = cnt_w(SMAX);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  gap;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  state_t          state, state1;
  logic [SW-1:0]   starve_cnt, starve_cnt1;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .state(state), .starve_cnt(starve_cnt)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .state(state1), .starve_cnt(starve_cnt1)
  );

  // ---------------- memories (data valid only in the last WAIT cycle) ----------------
  logic [DW-1:0] phys_mem [16];
  int            mm_left = 0;
  logic [3:0]    mm_idx = '0;
  always @(negedge clk) begin
    if (bus.mem_en) begin
      mm_idx  = bus.mem_addr[5:2];
      mm_left = LAT;
      if (bus.mem_we) phys_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
      bus.mem_rdata = $urandom;
    end else if (mm_left > 0) begin
      mm_left--;
      bus.mem_rdata = (mm_left == 0) ? phys_mem[mm_idx] : $urandom;
    end else begin
      bus.mem_rdata = $urandom;
    end
  end

  localparam logic [31:0] LAT1_WORD = 32'hCAFE_F00D;
  int mm1_left = 0;
  always @(negedge clk) begin
    if (bus1.mem_en) begin
      mm1_left = 1;
      bus1.mem_rdata = $urandom;
    end else if (mm1_left > 0) begin
      mm1_left--;
      bus1.mem_rdata = (mm1_left == 0) ? LAT1_WORD : $urandom;
    end else begin
      bus1.mem_rdata = $urandom;
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [DW-1:0] exp_q [$];   // expected read data of completions, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [DW-1:0] ref_mem [16];
  bit            m_busy = 0;
  int            m_s = 0;
  bit            m_port = 0;       // 1 = data access
  op_t           m_op;
  int            m_starve = 0;
  logic [DW-1:0] m_if_rd = '0, m_d_rd = '0;
  bit            rst_req = 1, rst_chk = 1;
  int            comp_port [$];
  int            comp_cyc [$];

  // ---------------- requesters ----------------
  op_t if_q [$], d_q [$];
  op_t if_cur = '0, d_cur = '0;
  bit  if_act = 0, d_act = 0;
  int  if_wait = 0, d_wait = 0;

  // One clock cycle: check this cycle's outputs, drive requests for the
  // rest of the cycle, then let the model arbitrate on them.
  task automatic step();
    bit e_if_done, e_d_done, e_en, e_we, win_d;
    logic [3:0] idx;
    @(negedge clk);
    cyc++;
    e_if_done = 0; e_d_done = 0; e_en = 0; e_we = 0;
    if (m_busy) begin
      idx = m_op.addr[5:2];
      if (cyc == m_s + 1) begin
        e_en = 1;
        e_we = m_port && m_op.we;
        check("mem_addr", bus.mem_addr, m_op.addr);
        if (e_we) check("mem_wdata", bus.mem_wdata, m_op.data);
      end
      if (cyc == m_s + 2 + LAT) begin
        comp_port.push_back(int'(m_port));
        comp_cyc.push_back(cyc);
        if (!m_port) begin
          e_if_done = 1;
          m_if_rd = ref_mem[idx];
          exp_q.push_back(m_if_rd);
          check("if_rdata", bus.if_rdata, exp_q.pop_front());
        end else begin
          e_d_done = 1;
          if (!m_op.we) m_d_rd = ref_mem[idx];
          exp_q.push_back(m_d_rd);
          check("d_rdata", bus.d_rdata, exp_q.pop_front());
        end
        check("starve_cnt", 32'(starve_cnt), m_starve);
      end
      if (cyc == m_s + 3 + LAT) m_busy = 0;
    end
    check("if_done", 32'(bus.if_done), 32'(e_if_done));
    check("d_done", 32'(bus.d_done), 32'(e_d_done));
    check("mem_en", 32'(bus.mem_en), 32'(e_en));
    check("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (rst_chk) begin
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_d_rdata", bus.d_rdata, 32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_starve", 32'(starve_cnt), 32'h0);
      rst_chk = 0;
    end
    // requesters: finish on done, then present the next op after its gap
    if (if_act && e_if_done) begin if_act = 0; if_wait = 0; end
    if (d_act && e_d_done) begin d_act = 0; d_wait = 0; end
    if (!if_act && if_q.size() > 0) begin
      if (if_wait >= int'(if_q[0].gap)) begin if_cur = if_q.pop_front(); if_act = 1; if_wait = 0; end
      else if_wait++;
    end
    if (!d_act && d_q.size() > 0) begin
      if (d_wait >= int'(d_q[0].gap)) begin d_cur = d_q.pop_front(); d_act = 1; d_wait = 0; end
      else d_wait++;
    end
    bus.if_req  = if_act;
    bus.if_addr = if_cur.addr;
    bus.d_req   = d_act;
    bus.d_we    = d_cur.we;
    bus.d_addr  = d_cur.addr;
    bus.d_wdata = d_cur.data;
    reset       = rst_req;
    #1;
    check("if_stall", 32'(bus.if_stall), 32'(if_act && !e_if_done));
    check("d_stall", 32'(bus.d_stall), 32'(d_act && !e_d_done));
    // model arbitration for this cycle
    if (rst_req) begin
      m_busy = 0; m_starve = 0; m_if_rd = '0; m_d_rd = '0; rst_chk = 1;
    end else if (!m_busy && (if_act || d_act)) begin
      win_d = d_act && !(m_starve == SMAX && if_act);
      if (win_d) begin
        if (if_act && m_starve < SMAX) m_starve++;
      end else begin
        m_starve = 0;
      end
      m_busy = 1;
      m_s    = cyc;
      m_port = win_d;
      m_op   = win_d ? d_cur : if_cur;
      if (!win_d) m_op.we = 0;
      if (win_d && d_cur.we) ref_mem[d_cur.addr[5:2]] = d_cur.data;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    int pending;
    while ((if_q.size() > 0 || d_q.size() > 0 || if_act || d_act || m_busy) && n < budget) begin
      step();
      n++;
    end
    pending = if_q.size() + d_q.size() + int'(if_act) + int'(d_act) + int'(m_busy);
    check("drain_pending", pending, 0);
    step();
  endtask

  function automatic op_t mk_op(input logic [31:0] addr, input logic we,
                                input logic [31:0] data, input int gap);
    op_t o;
    o.addr = addr; o.we = we; o.data = data; o.gap = 4'(gap);
    return o;
  endfunction

  task automatic test_lat1();
    @(negedge clk);
    bus1.if_addr = 32'h0000_000C;
    bus1.if_req  = 1'b1;
    check("lat1_done_c0", 32'(bus1.if_done), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat1_mem_en", 32'(bus1.mem_en), 32'(k == 1));
      check("lat1_if_done", 32'(bus1.if_done), 32'(k == 3));
      if (k == 3) begin
        check("lat1_if_rdata", bus1.if_rdata, LAT1_WORD);
        bus1.if_req = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_idle, n;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4]  = 32'hDEAD_BEEF;

    repeat (3) step();
    rst_req = 0;
    step();

    // single load
    d_q.push_back(mk_op(32'h10, 1'b0, 32'h0, 0));
    run_until_idle(40);
    check("single_load_data", bus.d_rdata, 32'hDEAD_BEEF);

    // store then load
    d_q.push_back(mk_op(32'h20, 1'b1, 32'h1234_5678, 0));
    run_until_idle(40);
    check("store_keeps_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    d_q.push_back(mk_op(32'h20, 1'b0, 32'h0, 0));
    run_until_idle(40);
    check("load_after_store", bus.d_rdata, 32'h1234_5678);

    // contention: both rise together, data first then fetch 5 cycles later
    comp_port.delete(); comp_cyc.delete();
    if_q.push_back(mk_op(32'h4, 1'b0, 32'h0, 0));
    d_q.push_back(mk_op(32'h10, 1'b0, 32'h0, 0));
    run_until_idle(60);
    check("contend_first_d", comp_port.size() > 0 ? comp_port[0] : -1, 1);
    check("contend_gap", comp_cyc.size() > 1 ? comp_cyc[1] - comp_cyc[0] : -1, 3 + LAT);

    // starvation: fetch waits behind four data accesses
    comp_port.delete(); comp_cyc.delete();
    if_q.push_back(mk_op(32'h8, 1'b0, 32'h0, 0));
    for (int i = 0; i < 6; i++) d_q.push_back(mk_op(32'(i * 4), 1'b0, 32'h0, 0));
    run_until_idle(100);
    check("starve_count", comp_port.size(), 7);
    for (int i = 0; i < 4; i++) check("starve_order_d", comp_port.size() > i ? comp_port[i] : -1, 1);
    check("starve_order_if", comp_port.size() > 4 ? comp_port[4] : -1, 0);
    check("starve_after_if", 32'(starve_cnt), 32'h0);

    // reset in the middle of a fetch
    comp_port.delete(); comp_cyc.delete();
    if_q.push_back(mk_op(32'h8, 1'b0, 32'h0, 0));
    n = 0;
    while (!(m_busy && cyc == m_s + 2) && n < 20) begin step(); n++; end
    rst_req = 1;
    step();
    rst_req = 0;
    first_idle = cyc + 1;
    run_until_idle(40);
    check("rst_done_count", comp_port.size(), 1);
    check("rst_reissue_gap", comp_cyc.size() > 0 ? comp_cyc[0] - first_idle : -1, 4);

    // random streams
    for (int i = 0; i < 40; i++) begin
      if_q.push_back(mk_op(32'($urandom_range(0, 15) * 4), 1'b0, 32'h0, $urandom_range(0, 3)));
      d_q.push_back(mk_op(32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
                          $urandom, $urandom_range(0, 3)));
    end
    run_until_idle(3000);

    test_lat1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
